// File: rtl/mem_wb_pipeline_register.sv
// mem_wb_pipeline_register
// MEM/WB pipeline register for the top and bottom byte lanes. It holds the
// current write-back entry and a one-deep history copy (t-1). The history
// copy feeds the MEM/WB input mux and the forwarding logic. It also counts
// retired instructions.
//
// Ports
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   stall                 hold every register (has priority over flush)
//   flush                 load a bubble into the current stage instead of the inputs
//   valid_in              incoming entry is a real instruction
//   data_*_in             lane data from the MEM/WB input mux
//   wb_en_*_in            lane write-enables (qualified by valid_in)
//   wb_addr_*_in          lane destination addresses
//   mem_wb_*              current-stage lane data
//   mem_wb_tm1_*          t-1 lane data
//   wb_en_*, wb_addr_*    current-stage write-back control
//   tm1_en_*, tm1_addr_*  t-1 write-back control (forwarding qualifiers)
//   occupancy             {tm1_valid, cur_valid}
//   retired_count         valid entries that have left the current stage (wraps)
module mem_wb_pipeline_register #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   valid_in,
  input  logic [DATA_WIDTH-1:0]  data_top_in,
  input  logic [DATA_WIDTH-1:0]  data_bot_in,
  input  logic                   wb_en_top_in,
  input  logic                   wb_en_bot_in,
  input  logic [ADDR_WIDTH-1:0]  wb_addr_top_in,
  input  logic [ADDR_WIDTH-1:0]  wb_addr_bot_in,
  output logic [DATA_WIDTH-1:0]  mem_wb_top,
  output logic [DATA_WIDTH-1:0]  mem_wb_bot,
  output logic [DATA_WIDTH-1:0]  mem_wb_tm1_top,
  output logic [DATA_WIDTH-1:0]  mem_wb_tm1_bot,
  output logic                   wb_en_top,
  output logic                   wb_en_bot,
  output logic [ADDR_WIDTH-1:0]  wb_addr_top,
  output logic [ADDR_WIDTH-1:0]  wb_addr_bot,
  output logic                   tm1_en_top,
  output logic                   tm1_en_bot,
  output logic [ADDR_WIDTH-1:0]  tm1_addr_top,
  output logic [ADDR_WIDTH-1:0]  tm1_addr_bot,
  output logic [1:0]             occupancy,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  // Current stage
  logic [DATA_WIDTH-1:0]  r_cur_data_top, r_cur_data_bot;
  logic                   r_cur_en_top, r_cur_en_bot;
  logic [ADDR_WIDTH-1:0]  r_cur_addr_top, r_cur_addr_bot;
  logic                   r_cur_valid;
  // t-1 history stage
  logic [DATA_WIDTH-1:0]  r_tm1_data_top, r_tm1_data_bot;
  logic                   r_tm1_en_top, r_tm1_en_bot;
  logic [ADDR_WIDTH-1:0]  r_tm1_addr_top, r_tm1_addr_bot;
  logic                   r_tm1_valid;
  logic [COUNT_WIDTH-1:0] r_retired;

  // Entry to load into the current stage: the inputs, or a bubble on flush
  logic                   w_load;
  logic [DATA_WIDTH-1:0]  w_nxt_data_top, w_nxt_data_bot;
  logic                   w_nxt_en_top, w_nxt_en_bot;
  logic [ADDR_WIDTH-1:0]  w_nxt_addr_top, w_nxt_addr_bot;
  logic                   w_nxt_valid;

  always_comb begin
    w_load         = ~flush;
    w_nxt_valid    = valid_in & w_load;
    // An invalid entry never carries a write-enable
    w_nxt_en_top   = wb_en_top_in & w_nxt_valid;
    w_nxt_en_bot   = wb_en_bot_in & w_nxt_valid;
    w_nxt_data_top = w_load ? data_top_in    : '0;
    w_nxt_data_bot = w_load ? data_bot_in    : '0;
    w_nxt_addr_top = w_load ? wb_addr_top_in : '0;
    w_nxt_addr_bot = w_load ? wb_addr_bot_in : '0;
  end

  // Pipeline advance: the current stage shifts into t-1 and new entry into current
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_data_top <= '0;
      r_cur_data_bot <= '0;
      r_cur_en_top   <= 1'b0;
      r_cur_en_bot   <= 1'b0;
      r_cur_addr_top <= '0;
      r_cur_addr_bot <= '0;
      r_cur_valid    <= 1'b0;
      r_tm1_data_top <= '0;
      r_tm1_data_bot <= '0;
      r_tm1_en_top   <= 1'b0;
      r_tm1_en_bot   <= 1'b0;
      r_tm1_addr_top <= '0;
      r_tm1_addr_bot <= '0;
      r_tm1_valid    <= 1'b0;
      r_retired      <= '0;
    end else if (!stall) begin
      r_tm1_data_top <= r_cur_data_top;
      r_tm1_data_bot <= r_cur_data_bot;
      r_tm1_en_top   <= r_cur_en_top;
      r_tm1_en_bot   <= r_cur_en_bot;
      r_tm1_addr_top <= r_cur_addr_top;
      r_tm1_addr_bot <= r_cur_addr_bot;
      r_tm1_valid    <= r_cur_valid;
      r_cur_data_top <= w_nxt_data_top;
      r_cur_data_bot <= w_nxt_data_bot;
      r_cur_en_top   <= w_nxt_en_top;
      r_cur_en_bot   <= w_nxt_en_bot;
      r_cur_addr_top <= w_nxt_addr_top;
      r_cur_addr_bot <= w_nxt_addr_bot;
      r_cur_valid    <= w_nxt_valid;
      // A valid entry leaving the current stage has retired
      if (r_cur_valid) begin
        r_retired <= r_retired + COUNT_WIDTH'(1);
      end
    end
  end

  assign mem_wb_top     = r_cur_data_top;
  assign mem_wb_bot     = r_cur_data_bot;
  assign mem_wb_tm1_top = r_tm1_data_top;
  assign mem_wb_tm1_bot = r_tm1_data_bot;
  assign wb_en_top      = r_cur_en_top;
  assign wb_en_bot      = r_cur_en_bot;
  assign wb_addr_top    = r_cur_addr_top;
  assign wb_addr_bot    = r_cur_addr_bot;
  assign tm1_en_top     = r_tm1_en_top;
  assign tm1_en_bot     = r_tm1_en_bot;
  assign tm1_addr_top   = r_tm1_addr_top;
  assign tm1_addr_bot   = r_tm1_addr_bot;
  assign occupancy      = {r_tm1_valid, r_cur_valid};
  assign retired_count  = r_retired;

endmodule

// File: tb/tb_mem_wb_pipeline_register.sv
// tb_mem_wb_pipeline_register
// Directed and randomized stimulus checked against a history-queue reference model.
// Each advance appends one entry to the history. The current stage is the last
// entry and t-1 is the one before it. The retired count is the number of valid
// entries that are no longer last.
module tb_mem_wb_pipeline_register;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [DW-1:0] dt;
    logic [DW-1:0] db;
    logic          et;
    logic          eb;
    logic [AW-1:0] at;
    logic [AW-1:0] ab;
    logic          v;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0, flush = 1'b0, valid_in = 1'b0;
  logic [DW-1:0] data_top_in = '0, data_bot_in = '0;
  logic          wb_en_top_in = 1'b0, wb_en_bot_in = 1'b0;
  logic [AW-1:0] wb_addr_top_in = '0, wb_addr_bot_in = '0;

  logic [DW-1:0] mem_wb_top, mem_wb_bot, mem_wb_tm1_top, mem_wb_tm1_bot;
  logic          wb_en_top, wb_en_bot, tm1_en_top, tm1_en_bot;
  logic [AW-1:0] wb_addr_top, wb_addr_bot, tm1_addr_top, tm1_addr_bot;
  logic [1:0]    occupancy;
  logic [CW-1:0] retired_count;

  int n_checks = 0;
  int n_fail   = 0;
  ent_t hist[$];

  mem_wb_pipeline_register #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clock(clk), .reset_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .data_top_in(data_top_in), .data_bot_in(data_bot_in),
    .wb_en_top_in(wb_en_top_in), .wb_en_bot_in(wb_en_bot_in),
    .wb_addr_top_in(wb_addr_top_in), .wb_addr_bot_in(wb_addr_bot_in),
    .mem_wb_top(mem_wb_top), .mem_wb_bot(mem_wb_bot),
    .mem_wb_tm1_top(mem_wb_tm1_top), .mem_wb_tm1_bot(mem_wb_tm1_bot),
    .wb_en_top(wb_en_top), .wb_en_bot(wb_en_bot),
    .wb_addr_top(wb_addr_top), .wb_addr_bot(wb_addr_bot),
    .tm1_en_top(tm1_en_top), .tm1_en_bot(tm1_en_bot),
    .tm1_addr_top(tm1_addr_top), .tm1_addr_bot(tm1_addr_bot),
    .occupancy(occupancy), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ent_t cur_e();
    return hist[hist.size()-1];
  endfunction

  function automatic ent_t tm1_e();
    return hist[hist.size()-2];
  endfunction

  function automatic logic [CW-1:0] model_retired();
    int n = 0;
    for (int i = 0; i < hist.size() - 1; i++) if (hist[i].v) n++;
    return CW'(n);
  endfunction

  task automatic check_all();
    ent_t c, p;
    c = cur_e();
    p = tm1_e();
    chk("mem_wb_top",     32'(mem_wb_top),     32'(c.dt));
    chk("mem_wb_bot",     32'(mem_wb_bot),     32'(c.db));
    chk("mem_wb_tm1_top", 32'(mem_wb_tm1_top), 32'(p.dt));
    chk("mem_wb_tm1_bot", 32'(mem_wb_tm1_bot), 32'(p.db));
    chk("wb_en_top",      32'(wb_en_top),      32'(c.et));
    chk("wb_en_bot",      32'(wb_en_bot),      32'(c.eb));
    chk("wb_addr_top",    32'(wb_addr_top),    32'(c.at));
    chk("wb_addr_bot",    32'(wb_addr_bot),    32'(c.ab));
    chk("tm1_en_top",     32'(tm1_en_top),     32'(p.et));
    chk("tm1_en_bot",     32'(tm1_en_bot),     32'(p.eb));
    chk("tm1_addr_top",   32'(tm1_addr_top),   32'(p.at));
    chk("tm1_addr_bot",   32'(tm1_addr_bot),   32'(p.ab));
    chk("occupancy",      32'(occupancy),      32'({p.v, c.v}));
    chk("retired_count",  32'(retired_count),  32'(model_retired()));
  endtask

  // Apply one cycle of inputs, let an edge pass, update the model, and compare
  task automatic step(input logic s, input logic f, input logic v,
                      input logic [DW-1:0] dt, input logic [DW-1:0] db,
                      input logic et, input logic eb,
                      input logic [AW-1:0] at, input logic [AW-1:0] ab);
    ent_t e;
    stall = s; flush = f; valid_in = v;
    data_top_in = dt; data_bot_in = db;
    wb_en_top_in = et; wb_en_bot_in = eb;
    wb_addr_top_in = at; wb_addr_bot_in = ab;
    @(posedge clk);
    #1;
    if (!s) begin
      if (f) e = '0;
      else e = '{dt: dt, db: db, et: et & v, eb: eb & v, at: at, ab: ab, v: v};
      hist.push_back(e);
    end
    check_all();
  endtask

  // Pulse reset between edges with busy inputs; outputs must clear at once
  task automatic do_reset(input logic s, input logic f);
    stall = s; flush = f; valid_in = 1'b1;
    data_top_in = 8'hC3; data_bot_in = 8'h3C;
    wb_en_top_in = 1'b1; wb_en_bot_in = 1'b1;
    wb_addr_top_in = 5'd9; wb_addr_bot_in = 5'd17;
    #2 rst_n = 1'b0;
    #1;
    hist.delete();
    hist.push_back('0);
    hist.push_back('0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_retired", 32'(retired_count), 32'd0);
    chk("rst_mem_wb_top", 32'(mem_wb_top), 32'd0);
    check_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0);

    // Stream of three valid entries
    step(0, 0, 1, 8'h11, 8'h01, 1, 1, 5'd1, 5'd2);
    step(0, 0, 1, 8'h22, 8'h02, 1, 0, 5'd3, 5'd4);
    step(0, 0, 1, 8'h33, 8'h03, 0, 1, 5'd5, 5'd6);
    chk("stream_top", 32'(mem_wb_top), 32'h33);
    chk("stream_tm1_top", 32'(mem_wb_tm1_top), 32'h22);
    chk("stream_occ", 32'(occupancy), 32'b11);
    chk("stream_retired", 32'(retired_count), 32'd2);

    // Stall holds everything, including across a flush request
    step(0, 0, 1, 8'hA5, 8'h5A, 1, 1, 5'd3, 5'd8);
    for (int i = 0; i < 3; i++)
      step(1, (i == 1), 1, 8'($urandom), 8'($urandom), 1, 1, 5'($urandom), 5'($urandom));
    chk("stall_top", 32'(mem_wb_top), 32'hA5);
    chk("stall_bot", 32'(mem_wb_bot), 32'h5A);
    chk("stall_tm1_top", 32'(mem_wb_tm1_top), 32'h33);
    chk("stall_retired", 32'(retired_count), 32'd3);
    step(0, 0, 1, 8'h44, 8'h55, 0, 0, 5'd0, 5'd0);
    chk("resume_top", 32'(mem_wb_top), 32'h44);
    chk("resume_tm1_top", 32'(mem_wb_tm1_top), 32'hA5);

    // Flush: bubble in current, prior entry keeps its control in t-1
    step(0, 0, 1, 8'h66, 8'h77, 1, 0, 5'd3, 5'd4);
    step(0, 1, 1, 8'h99, 8'h98, 1, 1, 5'd7, 5'd7);
    chk("flush_cur_valid", 32'(occupancy[0]), 32'd0);
    chk("flush_wb_en_top", 32'(wb_en_top), 32'd0);
    chk("flush_wb_addr_top", 32'(wb_addr_top), 32'd0);
    chk("flush_tm1_en_top", 32'(tm1_en_top), 32'd1);
    chk("flush_tm1_addr_top", 32'(tm1_addr_top), 32'd3);

    // Invalid entry never asserts a write-enable; same address in both lanes passes through
    step(0, 0, 0, 8'hEE, 8'hDD, 1, 1, 5'd12, 5'd12);
    chk("inv_wb_en_top", 32'(wb_en_top), 32'd0);
    chk("inv_wb_en_bot", 32'(wb_en_bot), 32'd0);
    step(0, 0, 1, 8'h10, 8'h20, 1, 1, 5'd12, 5'd12);
    chk("same_addr_bot", 32'(wb_addr_bot), 32'd12);

    // Reset during stall+flush, then the first advance loads the inputs
    do_reset(1'b1, 1'b1);
    step(0, 0, 1, 8'h5B, 8'hB5, 1, 0, 5'd21, 5'd22);
    chk("post_rst_top", 32'(mem_wb_top), 32'h5B);
    chk("post_rst_occ", 32'(occupancy), 32'b01);

    // Counter wrap: 17 retirements on a 4-bit counter
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 18; i++)
      step(0, 0, 1, 8'(i), 8'(~i), 1, 1, 5'(i), 5'(i + 1));
    chk("wrap_retired", 32'(retired_count), 32'd1);

    // Randomized traffic with a mid-run reset
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset(1'($urandom), 1'($urandom));
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0),
           8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
